// File: rtl/stream_demux_1_to_n.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1_to_n
// Description : Registered, handshaked 1-to-N packet demultiplexer. The
//               destination is sampled on the first beat of each packet and
//               held until in_last. Packets with an out-of-range select are
//               swallowed and counted in a saturating drop counter.
//               Unselected outputs always drive zeros.
// Ports       : clk, reset          - clock / async active-high reset
//               in_valid/ready/data/last/sel - input stream
//               out_valid/ready/data/last    - N_OUT output streams, channel
//                                              k at [k*DATA_W +: DATA_W]
//               busy      - mid-packet (routing or dropping)
//               cur_dest  - destination of current / most recent packet
//               drop_cnt  - saturating count of dropped packets
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1_to_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_dest,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [SEL_W:0] c_n_out = (SEL_W+1)'(N_OUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rv;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic [SEL_W-1:0]    r_dest;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_dest_ready;   // out_ready of the register's channel
    logic                w_sel_ok;
    logic                w_accept;
    logic                w_load;
    logic                w_drop_first;

    // out_ready is picked by comparison rather than indexing so a narrow
    // N_OUT never creates an out-of-range index.
    always_comb begin
        w_dest_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_dest == SEL_W'(k)) begin
                w_dest_ready = out_ready[k];
            end
        end
    end

    assign w_sel_ok     = ({1'b0, in_sel} < c_n_out);
    assign in_ready     = (r_state == S_DROP) || !r_rv || w_dest_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_load       = w_accept && ((r_state == S_ROUTE) ||
                                       ((r_state == S_IDLE) && w_sel_ok));
    assign w_drop_first = w_accept && (r_state == S_IDLE) && !w_sel_ok;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_IDLE:  w_state_nxt = in_last ? S_IDLE : (w_sel_ok ? S_ROUTE : S_DROP);
                S_ROUTE: w_state_nxt = in_last ? S_IDLE : S_ROUTE;
                S_DROP:  w_state_nxt = in_last ? S_IDLE : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register: a load takes priority over a drain, which makes the
    // simultaneous drain+load a seamless back-to-back transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rv   <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_dest <= '0;
        end else if (w_load) begin
            r_rv   <= 1'b1;
            r_data <= in_data;
            r_last <= in_last;
            if (r_state == S_IDLE) begin
                r_dest <= in_sel;
            end
        end else if (r_rv && w_dest_ready) begin
            r_rv <= 1'b0;
        end
    end

    // Only the first beat of an out-of-range packet counts; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop_first && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_last  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_rv && (r_dest == SEL_W'(k))) begin
                out_valid[k]                = 1'b1;
                out_data[k*DATA_W +: DATA_W] = r_data;
                out_last[k]                 = r_last;
            end
        end
    end

    // The register's destination only changes on a first beat, so it is also
    // the destination of the current or most recent packet.
    assign cur_dest = r_dest;
    assign busy     = (r_state != S_IDLE);
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
